mem_port_arbiter: RTL

Arbitrates the single-port `MainMemory` between the instruction-fetch requester and the load/store (data) requester of the MIPS core. Each access is registered and holds `memread`/`memwrite` for a fixed number of cycles. Read data is captured and returned with a one-cycle acknowledge pulse. The block sits between the core's IF/MEM stages and the main memory; it is the only driver of the memory control, address and write-data lines.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// mem_arb_pkg: shared types and default sizing for the memory port arbiter.
// Rev 1.0

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MEM_LAT = 2;
  localparam int CNT_W       = 4;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: round-robin arbiter sharing one memory port between fetch and load/store.
// Rev 1.0

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  grant_e            gnt_q, gnt_d;
  grant_e            last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_IF;
      last_q     <= GNT_IF;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          // On a tie the requester that did not win last time is served.
          if (if_req && d_req) begin
            gnt_d = (last_q == GNT_IF) ? GNT_D : GNT_IF;
          end else begin
            gnt_d = d_req ? GNT_D : GNT_IF;
          end
          last_d = gnt_d;
          if (gnt_d == GNT_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
          cnt_d   = LAT_M1;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == '0) begin
          // Each port has its own response register so its rdata holds across the other's accesses.
          if (gnt_q == GNT_D) begin
            d_rdata_d = we_q ? '0 : mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_read  = (state_q == ST_ACCESS) && !we_q;
    mem_write = (state_q == ST_ACCESS) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ack    = (state_q == ST_RESP) && (gnt_q == GNT_IF);
    d_ack     = (state_q == ST_RESP) && (gnt_q == GNT_D);
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    busy      = (state_q != ST_IDLE);
  end

endmodule

`default_nettype wire
